// File: rtl/pacman_motion.sv
// pacman_motion: owns Pacman's sprite origin. Once per frame it probes the
// maze wall memory in the requested or current direction and advances the
// 10x10 sprite one pixel, or holds it. Drives the origin and the isPac hit flag.
module pacman_motion #(
  parameter int PLAY_MAX = 246,
  parameter int START_X  = 123,
  parameter int START_Y  = 180
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VS,
  input  logic [7:0] keycode,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       wall_req,
  output logic [7:0] wall_qx,
  output logic [7:0] wall_qy,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [7:0] pac_mem_start_X,
  output logic [7:0] pac_mem_start_Y,
  output logic [1:0] pac_dir,
  output logic       isPac
);

  localparam logic [7:0] PLAY_MAX_B = PLAY_MAX[7:0];
  localparam logic [7:0] START_X_B  = START_X[7:0];
  localparam logic [7:0] START_Y_B  = START_Y[7:0];

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_LEFT  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    TRY_PEND,
    TRY_CUR,
    REQ,
    UPDATE
  } state_t;

  state_t     state;
  dir_t       pend_dir;
  dir_t       cur_dir;
  dir_t       move_dir;   // direction under test, held through REQ/UPDATE
  logic       move_pend;  // 1 when the outstanding probe is the pending turn
  logic [7:0] pos_x;
  logic [7:0] pos_y;

  logic vs_s1, vs_s2, vs_s3;
  logic frame_tick;

  dir_t       try_dir;
  logic [7:0] probe_x;
  logic [7:0] probe_y;
  logic       blocked;

  // Two-flop synchroniser for VS, then a registered rising-edge pulse.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single flop.
    if (RESET) begin
      vs_s1      <= 1'b0;
      vs_s2      <= 1'b0;
      vs_s3      <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= VS;
      vs_s2      <= vs_s1;
      vs_s3      <= vs_s2;
      frame_tick <= vs_s2 & ~vs_s3;
    end
  end

  // Latch the most recent recognised direction key; other codes are ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pend_dir <= DIR_RIGHT;
    end else begin
      case (keycode)
        8'h1A:   pend_dir <= DIR_UP;
        8'h04:   pend_dir <= DIR_LEFT;
        8'h16:   pend_dir <= DIR_DOWN;
        8'h07:   pend_dir <= DIR_RIGHT;
        default: pend_dir <= pend_dir;
      endcase
    end
  end

  // Probe point and playfield bound check for the direction being tried.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    try_dir = (state == TRY_PEND) ? pend_dir : cur_dir;
    probe_x = pos_x;
    probe_y = pos_y;
    blocked = 1'b0;
    unique case (try_dir)
      DIR_RIGHT: begin
        probe_x = pos_x + 8'd10;
        probe_y = pos_y + 8'd5;
        blocked = (pos_x >= PLAY_MAX_B);
      end
      DIR_LEFT: begin
        probe_x = pos_x - 8'd1;
        probe_y = pos_y + 8'd5;
        blocked = (pos_x == 8'd0);
      end
      DIR_UP: begin
        probe_x = pos_x + 8'd5;
        probe_y = pos_y - 8'd1;
        blocked = (pos_y == 8'd0);
      end
      DIR_DOWN: begin
        probe_x = pos_x + 8'd5;
        probe_y = pos_y + 8'd10;
        blocked = (pos_y >= PLAY_MAX_B);
      end
    endcase
  end

  // Per-frame motion FSM: try pending turn, then current direction, then move.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      wall_req  <= 1'b0;
      wall_qx   <= 8'd0;
      wall_qy   <= 8'd0;
      pos_x     <= START_X_B;
      pos_y     <= START_Y_B;
      cur_dir   <= DIR_RIGHT;
      move_dir  <= DIR_RIGHT;
      move_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (frame_tick) state <= (pend_dir != cur_dir) ? TRY_PEND : TRY_CUR;
        end
        TRY_PEND, TRY_CUR: begin
          if (blocked) begin
            state <= (state == TRY_PEND) ? TRY_CUR : IDLE;
          end else begin
            wall_qx   <= probe_x;
            wall_qy   <= probe_y;
            wall_req  <= 1'b1;
            move_dir  <= try_dir;
            move_pend <= (state == TRY_PEND);
            state     <= REQ;
          end
        end
        REQ: begin
          if (wall_ack) begin
            wall_req <= 1'b0;
            if (!wall_hit)      state <= UPDATE;
            else if (move_pend) state <= TRY_CUR;
            else                state <= IDLE;
          end
        end
        UPDATE: begin
          cur_dir <= move_dir;
          unique case (move_dir)
            DIR_RIGHT: pos_x <= pos_x + 8'd1;
            DIR_LEFT:  pos_x <= pos_x - 8'd1;
            DIR_UP:    pos_y <= pos_y - 8'd1;
            DIR_DOWN:  pos_y <= pos_y + 8'd1;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pac_mem_start_X = pos_x;
  assign pac_mem_start_Y = pos_y;
  assign pac_dir         = cur_dir;

  // Beam-in-sprite test, 10-bit compare against the zero-extended origin.
  logic [9:0] x_ext, y_ext;
  assign x_ext = {2'b00, pos_x};
  assign y_ext = {2'b00, pos_y};
  assign isPac = (DrawX >= x_ext) && (DrawX <= x_ext + 10'd9) &&
                 (DrawY >= y_ext) && (DrawY <= y_ext + 10'd9);

endmodule
